otp_keystream_gen: RTL

Generates the one-time-pad byte stream that drives the `otp` input of the stream cipher stage. It is built on a seedable 16-bit maximal-length Fibonacci LFSR. Each accepted byte advances the LFSR by 8 steps. Bytes are delivered over a valid/ready handshake so the cipher stage, or the controller in front of it, can stall the stream. A sender and a receiver seeded with the same value produce identical pads, so encrypt and decrypt stay in lock-step.

---
 rtl/otp_keystream_gen_if.sv | 23 ++
 rtl/otp_keystream_gen.sv | 91 +++++++++
 2 files changed

// File: rtl/otp_keystream_gen_if.sv
// Handshake and control bundle between the keystream generator and its consumer/controller.
// The master drives control and ready; the slave (the generator) drives the keystream side.
interface otp_keystream_gen_if;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        start;
    logic        stop;
    logic        otp_ready;
    logic [7:0]  otp;
    logic        otp_valid;
    logic [15:0] byte_count;
    logic        busy;

    modport master (
        output seed_load, seed_in, start, stop, otp_ready,
        input  otp, otp_valid, byte_count, busy
    );

    modport slave (
        input  seed_load, seed_in, start, stop, otp_ready,
        output otp, otp_valid, byte_count, busy
    );
endinterface

// File: rtl/otp_keystream_gen.sv
// One-time-pad byte generator: a seedable 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1)
// advanced 8 steps per accepted byte, streamed over a valid/ready handshake.
module otp_keystream_gen #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    otp_keystream_gen_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e      state_q;
    logic        otp_valid_q;
    logic        busy_q;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] count_q, count_d;
    logic        accept;

    // Eight single steps unrolled; the first feedback bit ends up in bit 7.
    function automatic logic [15:0] byte_advance(input logic [15:0] s);
        logic [15:0] t;
        logic        fb;
        t = s;
        for (int i = 0; i < 8; i++) begin
            fb = t[15] ^ t[13] ^ t[12] ^ t[10];
            t  = {t[14:0], fb};
        end
        return t;
    endfunction

    assign accept = otp_valid_q & bus.otp_ready;

    // Seed load outranks an accept in the same cycle: the byte is dropped, not counted.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        lfsr_d  = lfsr_q;
        count_d = count_q;
        if (bus.seed_load) begin
            lfsr_d  = (bus.seed_in == 16'h0000) ? SEED : bus.seed_in;
            count_d = 16'h0000;
        end else if (accept) begin
            lfsr_d  = byte_advance(lfsr_q);
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q     <= IDLE;
            otp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            lfsr_q      <= SEED;
            count_q     <= 16'h0000;
        end else begin
            lfsr_q  <= lfsr_d;
            count_q <= count_d;
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state_q     <= RUN;
                        otp_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_q     <= IDLE;
                        otp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    otp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.otp        = lfsr_q[7:0];
    assign bus.otp_valid  = otp_valid_q;
    assign bus.busy       = busy_q;
    assign bus.byte_count = count_q;

endmodule
